// File: rtl/imager_cfg_loader_if.sv
// Byte-stream input and checked-config output bundle of imager_cfg_loader.
// The host/shifter side uses master, the loader uses slave.
interface imager_cfg_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [39:0] cfg_word;
   logic        cfg_valid;
   logic        cfg_ack;
   logic        err_chk;
   logic        err_tmo;
   logic [7:0]  frame_cnt;

   modport master (
      output rx_data, rx_valid, cfg_ack,
      input  rx_ready, cfg_word, cfg_valid, err_chk, err_tmo, frame_cnt
   );

   modport slave (
      input  rx_data, rx_valid, cfg_ack,
      output rx_ready, cfg_word, cfg_valid, err_chk, err_tmo, frame_cnt
   );
endinterface

// File: rtl/imager_cfg_loader.sv
// Frames host bytes (header, five config bytes, XOR checksum) into a 40-bit
// config word and holds it for the SPI shifter until acknowledged.
module imager_cfg_loader #(
   parameter logic [7:0]  HEADER      = 8'hA5,
   parameter logic [15:0] TIMEOUT     = 16'd50000,
   parameter logic [39:0] DEFAULT_CFG = 40'h04_7800_1B44
) (
   input logic                SPI_CLK,
   input logic                RESETN_spi,
   imager_cfg_loader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DATA, CHK, PRESENT} state_e;

   localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  xor_q, xor_d;
   logic [39:0] shadow_q, shadow_d;
   logic [39:0] cfg_word_q, cfg_word_d;
   logic        cfg_valid_q, cfg_valid_d;
   logic        err_chk_q, err_chk_d;
   logic        err_tmo_q, err_tmo_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;

   logic rx_ready;
   logic acc;
   logic tmo_hit;

   assign rx_ready = (state_q != PRESENT);
   assign acc      = bus.rx_valid && rx_ready;
   // An accepted byte on the expiry cycle still wins; tmo_hit is only consulted without acc.
   assign tmo_hit  = (TIMEOUT != 16'd0) && (tmo_cnt_q == TMO_LAST);

   // NOTE: every *_d gets its hold value first so no path through the case can infer a latch.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      xor_d       = xor_q;
      shadow_d    = shadow_q;
      cfg_word_d  = cfg_word_q;
      cfg_valid_d = cfg_valid_q;
      err_chk_d   = 1'b0;
      err_tmo_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (acc && (bus.rx_data == HEADER)) begin
               state_d   = DATA;
               idx_d     = 3'd0;
               xor_d     = 8'h00;
               tmo_cnt_d = 16'd0;
            end
         end
         DATA: begin
            if (acc) begin
               shadow_d  = {shadow_q[31:0], bus.rx_data};
               xor_d     = xor_q ^ bus.rx_data;
               idx_d     = idx_q + 3'd1;
               tmo_cnt_d = 16'd0;
               if (idx_q == 3'd4) state_d = CHK;
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               shadow_d  = '0;
               state_d   = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         CHK: begin
            if (acc) begin
               tmo_cnt_d = 16'd0;
               if (bus.rx_data == xor_q) begin
                  cfg_word_d  = shadow_q;
                  cfg_valid_d = 1'b1;
                  state_d     = PRESENT;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = IDLE;
               end
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               shadow_d  = '0;
               state_d   = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         PRESENT: begin
            // Only an ack seen while the word is already presented counts.
            if (bus.cfg_ack && cfg_valid_q) begin
               cfg_valid_d = 1'b0;
               frame_cnt_d = frame_cnt_q + 8'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge SPI_CLK or negedge RESETN_spi) begin
      if (!RESETN_spi) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         xor_q       <= 8'h00;
         shadow_q    <= '0;
         cfg_word_q  <= DEFAULT_CFG;
         cfg_valid_q <= 1'b0;
         err_chk_q   <= 1'b0;
         err_tmo_q   <= 1'b0;
         frame_cnt_q <= 8'd0;
         tmo_cnt_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         xor_q       <= xor_d;
         shadow_q    <= shadow_d;
         cfg_word_q  <= cfg_word_d;
         cfg_valid_q <= cfg_valid_d;
         err_chk_q   <= err_chk_d;
         err_tmo_q   <= err_tmo_d;
         frame_cnt_q <= frame_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign bus.rx_ready  = rx_ready;
   assign bus.cfg_word  = cfg_word_q;
   assign bus.cfg_valid = cfg_valid_q;
   assign bus.err_chk   = err_chk_q;
   assign bus.err_tmo   = err_tmo_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_imager_cfg_loader.sv
// Scoreboard bench for imager_cfg_loader: expected words are queued as frames
// are driven and compared when cfg_valid rises.
module tb_imager_cfg_loader;

   localparam logic [7:0]  HDR     = 8'hA5;
   localparam int          TMO     = 16;
   localparam logic [39:0] DEF_CFG = 40'h04_7800_1B44;

   logic SPI_CLK = 1'b0;
   logic RESETN_spi;

   imager_cfg_loader_if bus ();

   imager_cfg_loader #(
      .HEADER      (HDR),
      .TIMEOUT     (16'(TMO)),
      .DEFAULT_CFG (DEF_CFG)
   ) dut (
      .SPI_CLK    (SPI_CLK),
      .RESETN_spi (RESETN_spi),
      .bus        (bus)
   );

   always #5 SPI_CLK = ~SPI_CLK;

   int n_vec  = 0;
   int n_miss = 0;
   int exp_cnt = 0;
   int both_hi = 0;
   int chk_pulses = 0;
   int tmo_pulses = 0;
   logic        prev_valid = 1'b0;
   logic [39:0] held_word  = '0;
   logic [39:0] sb[$];

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready) begin
         @(negedge SPI_CLK);
         guard++;
         if (guard > 1000) begin
            check("rx_ready_wait", {39'd0, bus.rx_ready}, 40'd1);
            break;
         end
      end
      @(negedge SPI_CLK);
      bus.rx_valid = 1'b0;
   endtask

   // Five config bytes plus checksum; chk_mask != 0 corrupts the checksum.
   task automatic send_body(input logic [39:0] w, input logic [7:0] chk_mask, input bit ack_with_chk);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < 5; i++) begin
         send_byte(w[39-8*i -: 8]);
         x ^= w[39-8*i -: 8];
      end
      if (chk_mask == 8'h00) sb.push_back(w);
      bus.cfg_ack = ack_with_chk;
      send_byte(x ^ chk_mask);
      bus.cfg_ack = 1'b0;
   endtask

   task automatic send_frame(input logic [39:0] w, input logic [7:0] chk_mask);
      send_byte(HDR);
      send_body(w, chk_mask, 1'b0);
   endtask

   task automatic do_ack();
      check("ack_pre_valid", {39'd0, bus.cfg_valid}, 40'd1);
      bus.cfg_ack = 1'b1;
      @(negedge SPI_CLK);
      bus.cfg_ack = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      check("ack_valid_low", {39'd0, bus.cfg_valid}, 40'd0);
      check("ack_frame_cnt", {32'd0, bus.frame_cnt}, 40'(exp_cnt));
      check("ack_rx_ready", {39'd0, bus.rx_ready}, 40'd1);
   endtask

   // Output monitor: scoreboard pop on cfg_valid rise, word stability while presented.
   always @(negedge SPI_CLK) begin
      if (!RESETN_spi) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.err_chk && bus.err_tmo) both_hi++;
         if (bus.err_chk) chk_pulses++;
         if (bus.err_tmo) tmo_pulses++;
         if (bus.cfg_valid && !prev_valid) begin
            check("sb_pending", {39'd0, sb.size() != 0}, 40'd1);
            if (sb.size() != 0) begin
               held_word = sb.pop_front();
               check("sb_word", bus.cfg_word, held_word);
            end
         end else if (bus.cfg_valid) begin
            check("word_stable", bus.cfg_word, held_word);
         end
         prev_valid = bus.cfg_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.cfg_ack  = 1'b0;
      RESETN_spi   = 1'b0;
      repeat (3) @(negedge SPI_CLK);
      check("rst_word", bus.cfg_word, DEF_CFG);
      check("rst_valid", {39'd0, bus.cfg_valid}, 40'd0);
      check("rst_ready", {39'd0, bus.rx_ready}, 40'd1);
      check("rst_cnt", {32'd0, bus.frame_cnt}, 40'd0);
      RESETN_spi = 1'b1;
      @(negedge SPI_CLK);

      // Good frame: cfg_valid is up right after the checksum edge.
      send_frame(40'h12_3456_789A, 8'h00);
      check("good_valid", {39'd0, bus.cfg_valid}, 40'd1);
      check("good_word", bus.cfg_word, 40'h12_3456_789A);
      repeat (3) @(negedge SPI_CLK);
      check("present_ready", {39'd0, bus.rx_ready}, 40'd0);
      do_ack();

      // Ack with nothing presented is ignored.
      bus.cfg_ack = 1'b1;
      @(negedge SPI_CLK);
      bus.cfg_ack = 1'b0;
      @(negedge SPI_CLK);
      check("stray_ack_cnt", {32'd0, bus.frame_cnt}, 40'(exp_cnt));

      // Garbage before the header is dropped.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_frame(40'hDE_AD_BE_EF_01, 8'h00);
      check("garbage_valid", {39'd0, bus.cfg_valid}, 40'd1);
      do_ack();

      // Bad checksum: one-cycle err_chk, word unchanged, back in IDLE.
      send_frame(40'h12_3456_789A, 8'h01);
      check("badchk_pulse", {39'd0, bus.err_chk}, 40'd1);
      check("badchk_valid", {39'd0, bus.cfg_valid}, 40'd0);
      check("badchk_word", bus.cfg_word, 40'hDE_AD_BE_EF_01);
      @(negedge SPI_CLK);
      check("badchk_pulse_end", {39'd0, bus.err_chk}, 40'd0);
      check("badchk_ready", {39'd0, bus.rx_ready}, 40'd1);

      // Ack coinciding with the checksum edge must not count.
      send_byte(HDR);
      send_body(40'h55_AA_00_FF_A5, 8'h00, 1'b1);
      check("early_ack_valid", {39'd0, bus.cfg_valid}, 40'd1);
      check("early_ack_cnt", {32'd0, bus.frame_cnt}, 40'(exp_cnt));
      do_ack();

      // Back-pressure: header held while a word is presented.
      send_frame(40'hC0_FFEE_1234, 8'h00);
      bus.rx_data  = HDR;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge SPI_CLK);
         check("bp_ready_low", {39'd0, bus.rx_ready}, 40'd0);
      end
      check("bp_word", bus.cfg_word, 40'hC0_FFEE_1234);
      do_ack();
      @(negedge SPI_CLK);
      bus.rx_valid = 1'b0;
      send_body(40'h01_0203_0405, 8'h00, 1'b0);
      check("bp_next_valid", {39'd0, bus.cfg_valid}, 40'd1);
      do_ack();

      // Reset mid-frame restores power-up state.
      send_byte(HDR);
      send_byte(8'h11);
      send_byte(8'h22);
      #2 RESETN_spi = 1'b0;
      #1;
      check("midrst_word", bus.cfg_word, DEF_CFG);
      check("midrst_valid", {39'd0, bus.cfg_valid}, 40'd0);
      check("midrst_ready", {39'd0, bus.rx_ready}, 40'd1);
      check("midrst_cnt", {32'd0, bus.frame_cnt}, 40'd0);
      exp_cnt = 0;
      @(negedge SPI_CLK);
      RESETN_spi = 1'b1;
      @(negedge SPI_CLK);
      send_frame(40'h66_7788_99AB, 8'h00);
      check("postrst_valid", {39'd0, bus.cfg_valid}, 40'd1);
      do_ack();

      // Timeout: err_tmo exactly TMO cycles after the last accepted byte.
      send_byte(HDR);
      send_byte(8'h11);
      send_byte(8'h22);
      for (int k = 1; k <= TMO + 1; k++) begin
         @(negedge SPI_CLK);
         check($sformatf("tmo_c%0d", k), {39'd0, bus.err_tmo}, 40'(k == TMO));
      end
      send_frame(40'h33_4455_6677, 8'h00);
      check("posttmo_valid", {39'd0, bus.cfg_valid}, 40'd1);
      do_ack();

      // Byte landing on the expiry edge wins over the timeout.
      send_byte(HDR);
      repeat (TMO - 1) @(negedge SPI_CLK);
      send_body(40'h89_ABCD_EF01, 8'h00, 1'b0);
      check("tie_valid", {39'd0, bus.cfg_valid}, 40'd1);
      do_ack();

      repeat (3) @(negedge SPI_CLK);
      check("sb_drained", 40'(sb.size()), 40'd0);
      check("err_both_high", 40'(both_hi), 40'd0);
      check("err_chk_pulses", 40'(chk_pulses), 40'd1);
      check("err_tmo_pulses", 40'(tmo_pulses), 40'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
